// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module mdu_iterative #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     dsr_q, dsr_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 bz_q, bz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 div0_q, div0_d;

    logic                 accept, mt_write, is_signed;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, rem_sh, trial;
    logic [2*WIDTH-1:0]   mul_next, div_next, step, prod;

    assign accept    = (state_q == S_IDLE) && start && !op[2];
    assign mt_write  = (state_q == S_IDLE) && start && (op[2:1] == 2'b10);
    assign is_signed = !op[0];
    assign a_mag     = (is_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag     = (is_signed && B[WIDTH-1]) ? -B : B;

    // Multiply: accumulate into the upper half, shift the multiplier out of the lower half.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dsr_q : '0)};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: remainder in the upper half, dividend bits shift out as quotient bits shift in.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, dsr_q};
    assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    assign step = is_div_q ? div_next : mul_next;
    assign prod = neg_q ? -step : step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_CALC;
            S_CALC:  if (cnt_q == CNT_ONE) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dsr_d     = dsr_q;
        a_d       = a_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bz_d      = bz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div0_d    = div0_q;
        if (accept) begin
            cnt_d     = CNT_INIT;
            a_d       = A;
            is_div_d  = op[1];
            bz_d      = (B == '0);
            neg_d     = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem_d = is_signed && A[WIDTH-1];
            div0_d    = 1'b0;
            if (op[1]) begin
                acc_d = {{WIDTH{1'b0}}, a_mag};
                dsr_d = b_mag;
            end else begin
                acc_d = {{WIDTH{1'b0}}, b_mag};
                dsr_d = a_mag;
            end
        end else if (mt_write) begin
            if (op[0]) lo_d = A;
            else       hi_d = A;
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q - CNT_ONE;
            acc_d = step;
            // Sign fix-up is applied on the final iteration so HI/LO change only on the DONE edge.
            if (cnt_q == CNT_ONE) begin
                if (!is_div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (bz_q) begin
                    hi_d   = a_q;
                    lo_d   = '1;
                    div0_d = 1'b1;
                end else begin
                    hi_d = neg_rem_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
                    lo_d = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            dsr_q     <= '0;
            a_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            div0_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dsr_q     <= dsr_d;
            a_q       <= a_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bz_q      <= bz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div0_q    <= div0_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign div0 = div0_q;

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle ALU in the execute stage of the MIPS core. It performs signed/unsigned multiply and divide by radix-2 iteration over WIDTH cycles. It also services MTHI/MTLO writes, and exposes HI/LO continuously for MFHI/MFLO. A start/busy/done handshake lets the pipeline stall while an operation is in flight.

## Interface
- WIDTH, 32: operand and HI/LO width; legal values ≥ 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- A  in  WIDTH  operand 1 (multiplicand/dividend; MTHI/MTLO source).
- B  in  WIDTH  operand 2 (multiplier/divisor).
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).
- div0  out  1  set when a DIV/DIVU with B = 0 completes; cleared by next accepted start.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE→CALC on start with op ∈ {000..011}.
  - CALC→DONE after exactly WIDTH iterations. An internal counter of width $clog2(WIDTH)+1 counts down from WIDTH.
  - DONE→IDLE unconditionally.
- A, B and op are latched at acceptance. Input changes during CALC/DONE have no effect.
- MULT/MULTU: shift-add over WIDTH cycles. Signed mode multiplies magnitudes and negates the 2·WIDTH result if operand signs differ. {hi,lo} = full 2·WIDTH product.
- DIV/DIVU: restoring shift-subtract over WIDTH cycles on magnitudes. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative ÷ −1 wraps: lo = most-negative, hi = 0.
- Divide by zero: lo = all ones, hi = A (dividend unmodified), div0 = 1. The operation still takes full latency.
- MTHI/MTLO: start in IDLE writes A into hi/lo at that edge. No state change, busy stays 0, done not pulsed, div0 untouched.
- Reserved op with start: ignored entirely.
- start while busy = 1: ignored. No queueing.
- hi/lo are updated only on the CALC→DONE edge or an MTHI/MTLO edge. They are stable at all other times, including through CALC.
- Reset (asynchronous, any state): state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div0 = 0. Any in-flight operation is discarded.

## Timing
- Cycle 0: start = 1 sampled at end-of-cycle edge.
- Cycles 1..WIDTH: CALC, busy = 1, done = 0, hi/lo still show old values.
- Cycle WIDTH+1: DONE, busy = 1, done = 1, hi/lo/div0 show the new result.
- Cycle WIDTH+2: IDLE, busy = 0; a new start is accepted this cycle.
- Start-to-done latency is WIDTH+1 cycles; back-to-back issue interval is WIDTH+2 cycles.
- MTHI/MTLO: value visible on hi/lo in cycle 1; a long op may start in cycle 1.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=32, MULT A=FFFFFFFD (−3), B=00000007 → done 33 cycles after start; hi=FFFFFFFF, lo=FFFFFFEB; busy 1 for cycles 1..33.
- MULTU A=FFFFFFFF, B=FFFFFFFF → hi=FFFFFFFE, lo=00000001. Then DIV A=FFFFFFF9 (−7), B=2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIV A=80000000, B=FFFFFFFF → lo=80000000, hi=00000000, div0=0. Then DIVU A=7, B=0 → lo=FFFFFFFF, hi=00000007, div0=1; next start clears div0.
- Start DIVU 100/7 while in CALC with MULT 2×3 pending, and change A/B mid-CALC → only hi=0, lo=6 reported; second start ignored; one done pulse.
- MTHI A=12345678, then next cycle MTLO A=9ABCDEF0 → hi=12345678 (cycle 1), lo=9ABCDEF0 (cycle 2); busy and done stay 0.
- Assert rst_n=0 mid-CALC (cycle 10) → hi=lo=0, busy=done=div0=0 immediately; no done after release. Repeat MULTU 5×9 at WIDTH=8 → hi=00, lo=2D, done 9 cycles after start.
